// File: rtl/cpu_pkg.sv
// Shared types for the hazard/forwarding controller:
// forwarding select encoding and the shadow-stage record.
package cpu_pkg;

    localparam int HZ_REG_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rs1;
        logic [HZ_REG_W-1:0] rs2;
        logic                uses_rs1;
        logic                uses_rs2;
        logic [HZ_REG_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
        logic                multicycle;
    } hz_stage_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand.
// Ports: src_i (EX source), MEM/WB writer flag + rd, sel_o.
module hazard_fwd_sel
    import cpu_pkg::*;
#(
    parameter int W = HZ_REG_W
) (
    input  logic [W-1:0] src_i,
    input  logic         mem_wr_i,
    input  logic [W-1:0] mem_rd_i,
    input  logic         wb_wr_i,
    input  logic [W-1:0] wb_rd_i,
    output fwd_sel_e     sel_o
);

    logic mem_hit;
    logic wb_hit;

    // x0 is never a writer; MEM is the younger result.
    assign mem_hit = mem_wr_i && (mem_rd_i != '0)
                     && (mem_rd_i == src_i);
    assign wb_hit  = wb_wr_i && (wb_rd_i != '0)
                     && (wb_rd_i == src_i);

    always_comb begin
        sel_o = FWD_NONE;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard and forwarding controller.
// Inputs: clk/rst, ID fields, branch_taken, ext_stall.
// Outputs: pc/if enables, flush/bubble/stall, EX fwd selects.
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LATENCY = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_multicycle_i,
    input  logic                  branch_taken_i,
    input  logic                  ext_stall_i,
    output logic                  pc_en_o,
    output logic                  if_en_o,
    output logic                  if_flush_o,
    output logic                  id_bubble_o,
    output logic                  ex_stall_o,
    output logic                  mem_bubble_o,
    output fwd_sel_e              fwd_a_o,
    output fwd_sel_e              fwd_b_o
);

    localparam int CNT_W = $clog2(MC_LATENCY + 1);
    localparam logic [CNT_W-1:0] MC_LOAD =
        CNT_W'(MC_LATENCY - 1);

    hz_stage_t        ex_q, ex_d;
    hz_stage_t        mem_q, mem_d;
    hz_stage_t        wb_q, wb_d;
    hz_stage_t        id_stage;
    logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;

    logic     mc_busy;
    logic     lu_hit1;
    logic     lu_hit2;
    logic     load_use;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;
    logic     unused_fields;

    always_comb begin
        id_stage            = '0;
        id_stage.valid      = id_valid_i;
        id_stage.rs1        = HZ_REG_W'(id_rs1_i);
        id_stage.rs2        = HZ_REG_W'(id_rs2_i);
        id_stage.uses_rs1   = id_uses_rs1_i;
        id_stage.uses_rs2   = id_uses_rs2_i;
        id_stage.rd         = HZ_REG_W'(id_rd_i);
        id_stage.reg_write  = id_reg_write_i;
        id_stage.mem_read   = id_mem_read_i;
        id_stage.multicycle = id_multicycle_i;
    end

    assign mc_busy  = (mc_cnt_q != '0);
    assign lu_hit1  = id_uses_rs1_i
                      && (id_stage.rs1 == ex_q.rd);
    assign lu_hit2  = id_uses_rs2_i
                      && (id_stage.rs2 == ex_q.rd);
    assign load_use = ex_q.valid && ex_q.mem_read
                      && (ex_q.rd != '0)
                      && (lu_hit1 || lu_hit2);

    always_comb begin
        pc_en_o      = 1'b1;
        if_en_o      = 1'b1;
        if_flush_o   = 1'b0;
        id_bubble_o  = 1'b0;
        ex_stall_o   = 1'b0;
        mem_bubble_o = 1'b0;
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        mc_cnt_d     = mc_cnt_q;
        if (rst_i) begin
            pc_en_o     = 1'b0;
            if_en_o     = 1'b0;
            if_flush_o  = 1'b1;
            id_bubble_o = 1'b1;
        end else if (ext_stall_i) begin
            // Whole pipe frozen: shadow and count hold.
            pc_en_o = 1'b0;
            if_en_o = 1'b0;
        end else if (mc_busy) begin
            pc_en_o      = 1'b0;
            if_en_o      = 1'b0;
            ex_stall_o   = 1'b1;
            mem_bubble_o = 1'b1;
            mem_d        = '0;
            wb_d         = mem_q;
            mc_cnt_d     = mc_cnt_q - CNT_W'(1);
        end else if (load_use) begin
            pc_en_o     = 1'b0;
            if_en_o     = 1'b0;
            id_bubble_o = 1'b1;
            ex_d        = '0;
            mem_d       = ex_q;
            wb_d        = mem_q;
        end else begin
            // Branch only acts when ID really advances.
            if_flush_o = branch_taken_i;
            ex_d       = id_stage;
            mem_d      = ex_q;
            wb_d       = mem_q;
            mc_cnt_d   = (id_valid_i && id_multicycle_i)
                         ? MC_LOAD : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            mc_cnt_q <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    hazard_fwd_sel #(.W(HZ_REG_W)) u_fwd_a (
        .src_i    (ex_q.rs1),
        .mem_wr_i (mem_q.valid && mem_q.reg_write),
        .mem_rd_i (mem_q.rd),
        .wb_wr_i  (wb_q.valid && wb_q.reg_write),
        .wb_rd_i  (wb_q.rd),
        .sel_o    (fwd_a)
    );

    hazard_fwd_sel #(.W(HZ_REG_W)) u_fwd_b (
        .src_i    (ex_q.rs2),
        .mem_wr_i (mem_q.valid && mem_q.reg_write),
        .mem_rd_i (mem_q.rd),
        .wb_wr_i  (wb_q.valid && wb_q.reg_write),
        .wb_rd_i  (wb_q.rd),
        .sel_o    (fwd_b)
    );

    always_comb begin
        fwd_a_o = rst_i ? FWD_NONE : fwd_a;
        fwd_b_o = rst_i ? FWD_NONE : fwd_b;
    end

    // Stage fields kept for visibility but not decoded here.
    assign unused_fields = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed stimulus,
// per-cycle reference model plus literal spot checks.
module tb_hazard_unit;
    import cpu_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_i;
    logic id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic id_uses_rs1_i, id_uses_rs2_i;
    logic id_reg_write_i, id_mem_read_i;
    logic id_multicycle_i;
    logic branch_taken_i, ext_stall_i;
    logic pc_en_o, if_en_o, if_flush_o;
    logic id_bubble_o, ex_stall_o, mem_bubble_o;
    fwd_sel_e fwd_a_o, fwd_b_o;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_unit #(.REG_ADDR_W(5), .MC_LATENCY(LAT)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .id_valid_i      (id_valid_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_uses_rs1_i   (id_uses_rs1_i),
        .id_uses_rs2_i   (id_uses_rs2_i),
        .id_rd_i         (id_rd_i),
        .id_reg_write_i  (id_reg_write_i),
        .id_mem_read_i   (id_mem_read_i),
        .id_multicycle_i (id_multicycle_i),
        .branch_taken_i  (branch_taken_i),
        .ext_stall_i     (ext_stall_i),
        .pc_en_o         (pc_en_o),
        .if_en_o         (if_en_o),
        .if_flush_o      (if_flush_o),
        .id_bubble_o     (id_bubble_o),
        .ex_stall_o      (ex_stall_o),
        .mem_bubble_o    (mem_bubble_o),
        .fwd_a_o         (fwd_a_o),
        .fwd_b_o         (fwd_b_o)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       u1, u2, wr, ld, mc;
    } rec_t;

    rec_t m_ex, m_mem, m_wb;
    int   m_left = 0;
    rec_t n_ex, n_mem, n_wb;
    int   n_left;

    function automatic bit [1:0] mfwd(bit [4:0] s,
                                      rec_t a, rec_t b);
        if (a.v && a.wr && a.rd != 0 && a.rd == s)
            return 2'd2;
        if (b.v && b.wr && b.rd != 0 && b.rd == s)
            return 2'd1;
        return 2'd0;
    endfunction

    always @(negedge clk) begin : model
        rec_t idr, empty;
        bit [7:0] e;
        bit [1:0] ea, eb;
        bit lu, mh;
        empty = '{default: 0};
        idr.v  = id_valid_i;
        idr.rs1 = id_rs1_i;
        idr.rs2 = id_rs2_i;
        idr.rd  = id_rd_i;
        idr.u1  = id_uses_rs1_i;
        idr.u2  = id_uses_rs2_i;
        idr.wr  = id_reg_write_i;
        idr.ld  = id_mem_read_i;
        idr.mc  = id_multicycle_i;
        lu = m_ex.v && m_ex.ld && m_ex.rd != 0 &&
             ((idr.u1 && idr.rs1 == m_ex.rd) ||
              (idr.u2 && idr.rs2 == m_ex.rd));
        ea = mfwd(m_ex.rs1, m_mem, m_wb);
        eb = mfwd(m_ex.rs2, m_mem, m_wb);
        n_ex = m_ex; n_mem = m_mem; n_wb = m_wb;
        n_left = m_left;
        // e = {pc,if,flush,idb,exs,memb}
        if (rst_i) begin
            e = 8'b00_1100; ea = 0; eb = 0;
            n_ex = empty; n_mem = empty; n_wb = empty;
            n_left = 0;
        end else if (ext_stall_i) begin
            e = 8'b00_0000;
        end else if (m_left > 0) begin
            e = 8'b00_0011;
            n_mem = empty; n_wb = m_mem;
            n_left = m_left - 1;
        end else if (lu) begin
            e = 8'b00_0100;
            n_ex = empty; n_mem = m_ex; n_wb = m_mem;
        end else begin
            e = {2'b0, 2'b11, branch_taken_i, 3'b000};
            n_ex = idr; n_mem = m_ex; n_wb = m_mem;
            n_left = (idr.v && idr.mc) ? LAT - 1 : 0;
        end
        check("pc_en", pc_en_o, e[5]);
        check("if_en", if_en_o, e[4]);
        check("if_flush", if_flush_o, e[3]);
        check("id_bubble", id_bubble_o, e[2]);
        check("ex_stall", ex_stall_o, e[1]);
        check("mem_bubble", mem_bubble_o, e[0]);
        check("fwd_a", fwd_a_o, ea);
        check("fwd_b", fwd_b_o, eb);
        // A load in MEM must never feed the EX instruction.
        mh = !rst_i && dut.ex_q.valid && dut.mem_q.valid &&
             dut.mem_q.mem_read && dut.mem_q.rd != 0 &&
             ((dut.ex_q.uses_rs1 &&
               dut.ex_q.rs1 == dut.mem_q.rd) ||
              (dut.ex_q.uses_rs2 &&
               dut.ex_q.rs2 == dut.mem_q.rd));
        check("load_in_mem_fed", mh, 0);
    end

    always @(posedge clk) begin
        m_ex   <= n_ex;
        m_mem  <= n_mem;
        m_wb   <= n_wb;
        m_left <= n_left;
    end

    // ---------------- stimulus ----------------
    task automatic set_id(bit v, bit [4:0] r1, bit u1,
                          bit [4:0] r2, bit u2, bit [4:0] rd,
                          bit wr, bit ld, bit mc);
        id_valid_i = v;
        id_rs1_i = r1; id_uses_rs1_i = u1;
        id_rs2_i = r2; id_uses_rs2_i = u2;
        id_rd_i = rd; id_reg_write_i = wr;
        id_mem_read_i = ld; id_multicycle_i = mc;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : drive
        int cnt;
        rst_i = 1; ext_stall_i = 0; branch_taken_i = 0;
        nop();
        tick(); #2;
        check("rst_pc_en", pc_en_o, 0);
        check("rst_flush", if_flush_o, 1);
        check("rst_fwd_a", fwd_a_o, FWD_NONE);
        tick(); rst_i = 0; #2;
        check("post_rst_pc_en", pc_en_o, 1);
        check("post_rst_if_en", if_en_o, 1);

        // load x5 then ADD x6 = x5 + x7
        tick(); set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); #2;
        tick(); set_id(1, 5, 1, 7, 1, 6, 1, 0, 0); #2;
        check("lu_pc_en", pc_en_o, 0);
        check("lu_bubble", id_bubble_o, 1);
        tick(); #2;
        check("lu_resume", pc_en_o, 1);
        // ADD x3; SUB x4 = x8 - x3; OR x9 = x3 | x10
        tick(); set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); #2;
        check("lu_fwd_wb", fwd_a_o, FWD_WB);
        tick(); set_id(1, 8, 1, 3, 1, 4, 1, 0, 0); #2;
        tick(); set_id(1, 3, 1, 10, 1, 9, 1, 0, 0); #2;
        check("sub_fwd_b", fwd_b_o, FWD_MEM);
        check("sub_fwd_a", fwd_a_o, FWD_NONE);
        tick(); nop(); #2;
        check("or_fwd_a", fwd_a_o, FWD_WB);
        check("or_nostall", pc_en_o, 1);

        // MUL x11, then independent ADD x12
        tick(); set_id(1, 1, 1, 2, 1, 11, 1, 0, 1); #2;
        tick(); set_id(1, 13, 1, 14, 1, 12, 1, 0, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!ex_stall_o) break;
            cnt++;
            check("mul_mem_bubble", mem_bubble_o, 1);
            tick();
        end
        check("mul_stall_cycles", cnt, LAT - 1);
        check("mul_resume", pc_en_o, 1);

        // MUL x15 = x12 * x11 with 2-cycle ext stall inside
        tick(); nop(); #2;
        tick(); set_id(1, 12, 1, 11, 1, 15, 1, 0, 1); #2;
        tick(); nop();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            ext_stall_i = (i == 1 || i == 2);
            #2;
            if (pc_en_o) break;
            cnt++;
            if (i == 0)
                check("mul2_fwd_a0", fwd_a_o, FWD_WB);
            if (i == 1 || i == 2) begin
                check("ext_fwd_a", fwd_a_o, FWD_NONE);
                check("ext_fwd_b", fwd_b_o, FWD_NONE);
                check("ext_ex_stall", ex_stall_o, 0);
            end
            tick();
        end
        ext_stall_i = 0;
        check("mul2_total_stall", cnt, 5);

        // LW x20, then taken branch reading x20
        tick(); set_id(1, 1, 1, 0, 0, 20, 1, 1, 0); #2;
        tick(); set_id(1, 20, 1, 0, 0, 0, 0, 0, 0);
        branch_taken_i = 1; #2;
        check("br_lu_flush", if_flush_o, 0);
        check("br_lu_bubble", id_bubble_o, 1);
        tick(); #2;
        check("br_flush", if_flush_o, 1);
        check("br_pc_en", pc_en_o, 1);
        tick(); branch_taken_i = 0; nop(); #2;
        check("br_flush_once", if_flush_o, 0);

        // load to x0, then reader of x0
        tick(); set_id(1, 1, 1, 0, 0, 0, 1, 1, 0); #2;
        tick(); set_id(1, 0, 1, 0, 1, 21, 1, 0, 0); #2;
        check("x0_nostall", pc_en_o, 1);
        tick(); nop(); #2;
        check("x0_fwd_a", fwd_a_o, FWD_NONE);
        check("x0_fwd_b", fwd_b_o, FWD_NONE);
        tick(); #2;

        // reset in the middle of a MUL stall
        tick(); set_id(1, 1, 1, 2, 1, 22, 1, 0, 1); #2;
        tick(); nop(); #2;
        check("mid_mul_stall", ex_stall_o, 1);
        tick(); rst_i = 1; #2;
        check("mid_rst_pc_en", pc_en_o, 0);
        check("mid_rst_ex_stall", ex_stall_o, 0);
        tick(); rst_i = 0; #2;
        check("after_rst_pc_en", pc_en_o, 1);
        check("after_rst_ex_stall", ex_stall_o, 0);
        tick(); tick(); #2;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
